// File: rtl/alu_arbiter_if.sv
// Bundle of signals between two ALU requesters, the arbiter, the shared ALU
// and the result consumer.
interface alu_arbiter_if;
  logic        req0;
  logic        req1;
  logic [3:0]  op0;
  logic [3:0]  op1;
  logic [31:0] a0;
  logic [31:0] b0;
  logic [31:0] a1;
  logic [31:0] b1;
  logic        gnt0;
  logic        gnt1;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_cntrl;
  logic [31:0] alu_lo;
  logic [31:0] alu_hi;
  logic [31:0] res_lo;
  logic [31:0] res_hi;
  logic        res_valid;
  logic        res_id;
  logic        res_err;
  logic        res_ack;
  logic        busy;

  // Arbiter side: serves the requesters, drives the ALU, publishes results
  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, alu_lo, alu_hi, res_ack,
    output gnt0, gnt1, alu_a, alu_b, alu_cntrl,
           res_lo, res_hi, res_valid, res_id, res_err, busy
  );

  // Environment side: requesters, ALU and result consumer
  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, alu_lo, alu_hi, res_ack,
    input  gnt0, gnt1, alu_a, alu_b, alu_cntrl,
           res_lo, res_hi, res_valid, res_id, res_err, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared ALU. One operation
// is in flight at a time: grant, hold operands while the ALU settles
// (multi-cycle for mul/div), capture the result and hold it until acked.
module alu_arbiter #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input logic          clock,
  input logic          clear,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] MULDIV_LOAD = 4'(MULDIV_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        last;
  logic        owner;

  logic        pick_any;
  logic        pick_id;
  logic [3:0]  pick_op;
  logic [31:0] pick_a;
  logic [31:0] pick_b;
  logic        pick_muldiv;
  logic        cur_muldiv;
  logic        cur_illegal;

  // Decide which requester would win a grant this cycle (ties go to the one that did not win the last tie)
  always_comb begin
    pick_any = bus.req0 | bus.req1;
    pick_id  = 1'b0;
    pick_op  = bus.op0;
    pick_a   = bus.a0;
    pick_b   = bus.b0;
    if (bus.req0 && bus.req1) begin
      pick_id = ~last;
    end else begin
      pick_id = bus.req1;
    end
    if (pick_id) begin
      pick_op = bus.op1;
      pick_a  = bus.a1;
      pick_b  = bus.b1;
    end
  end

  assign pick_muldiv = (pick_op == 4'd10) || (pick_op == 4'd11);
  assign cur_muldiv  = (bus.alu_cntrl == 4'd10) || (bus.alu_cntrl == 4'd11);
  assign cur_illegal = (bus.alu_cntrl >= 4'd12);

  // Main control FSM; every output is a register so nothing on req/op reaches gnt combinationally
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      last          <= 1'b1;
      owner         <= 1'b0;
      bus.gnt0      <= 1'b0;
      bus.gnt1      <= 1'b0;
      bus.alu_a     <= 32'd0;
      bus.alu_b     <= 32'd0;
      bus.alu_cntrl <= 4'd0;
      bus.res_lo    <= 32'd0;
      bus.res_hi    <= 32'd0;
      bus.res_valid <= 1'b0;
      bus.res_id    <= 1'b0;
      bus.res_err   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.gnt0 <= 1'b0;
      bus.gnt1 <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            bus.gnt0      <= ~pick_id;
            bus.gnt1      <= pick_id;
            bus.alu_a     <= pick_a;
            bus.alu_b     <= pick_b;
            bus.alu_cntrl <= pick_op;
            owner         <= pick_id;
            if (bus.req0 && bus.req1) begin
              last <= pick_id;
            end
            cnt      <= pick_muldiv ? MULDIV_LOAD : 4'd0;
            bus.busy <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            bus.res_lo    <= cur_illegal ? 32'd0 : bus.alu_lo;
            bus.res_hi    <= cur_muldiv ? bus.alu_hi : 32'd0;
            bus.res_err   <= cur_illegal;
            bus.res_id    <= owner;
            bus.res_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ack) begin
            bus.res_valid <= 1'b0;
            bus.res_err   <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
